step_scheduler: RTL and testbench

Playback and edit scheduler for the 16-step sequencer. It advances a step pointer at a fixed tick rate, latches each step's 3-bit pitch from the model's beat store, and drives note, gate and step strobes to the sound/LED logic. It also converts decoded button presses from the button matrix controller into pitch-increment write requests for the model's `data_in` port, over a ready/valid handshake. It sits between the model, the button matrix controller and the audio/indicator outputs in `top`.

---
 rtl/step_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_step_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_scheduler.sv
// Step sequencer playback scheduler: steps, note/gate strobes, and
// button-press to pitch-increment edit requests toward the beat store.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   run              1 = play, 0 = stop
//   beats_flat[47:0] 16 x 3-bit beat pitches, beat i at [3i+2:3i]
//   button_valid     one-cycle press strobe, button_index[3:0] its beat
//   edit_ready       model accepts the pending write this cycle
//   step_index[3:0]  current step
//   note[2:0]        pitch latched at step start (0 = rest)
//   gate             note-on, first GATE_TICKS cycles of a sounding step
//   step_pulse       one-cycle strobe at each step start
//   edit_valid       write request pending
//   edit_data[6:0]   {beat_index, new_pitch}
//   edit_drop        one-cycle strobe: a press was discarded
module step_scheduler #(
  parameter int TICKS_PER_STEP = 3_000_000,
  parameter int GATE_TICKS     = 1_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [47:0] beats_flat,
  input  logic        button_valid,
  input  logic [3:0]  button_index,
  input  logic        edit_ready,
  output logic [3:0]  step_index,
  output logic [2:0]  note,
  output logic        gate,
  output logic        step_pulse,
  output logic        edit_valid,
  output logic [6:0]  edit_data,
  output logic        edit_drop
);

  localparam int TW = (TICKS_PER_STEP > 2)
                    ? $clog2(TICKS_PER_STEP) : 1;

  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICKS_PER_STEP - 1);
  localparam logic [TW-1:0] GATE_LAST =
    TW'(GATE_TICKS - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_GATE,
    ST_REST
  } state_e;

  state_e      state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]  step_q, step_d;
  logic [2:0]  note_q, note_d;
  logic        gate_q, gate_d;
  logic        pulse_q, pulse_d;
  logic        ev_q, ev_d;
  logic [6:0]  ed_q, ed_d;
  logic        drop_q, drop_d;

  logic [2:0]  beat [16];
  logic [3:0]  step_nxt;
  logic [2:0]  nxt_note;
  logic [2:0]  btn_pitch;
  logic        at_last;
  logic        at_gate_end;

  for (genvar g = 0; g < 16; g++) begin : g_beat
    assign beat[g] = beats_flat[3*g +: 3];
  end

  assign step_nxt    = step_q + 4'd1;
  assign nxt_note    = beat[step_nxt];
  assign at_last     = (tick_q == TICK_LAST);
  assign at_gate_end = (tick_q == GATE_LAST);

  // 3-bit add: pitch 7 wraps to 0
  assign btn_pitch = beat[button_index] + 3'd1;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = step_q;
    note_d  = note_q;
    gate_d  = gate_q;
    pulse_d = 1'b0;
    unique case (state_q)
      ST_STOP: begin
        gate_d = 1'b0;
        tick_d = '0;
        if (run) begin
          state_d = ST_GATE;
          step_d  = 4'd0;
          note_d  = beat[0];
          gate_d  = |beat[0];
          pulse_d = 1'b1;
        end
      end
      ST_GATE, ST_REST: begin
        if (!run) begin
          // stop wins over a coincident boundary
          state_d = ST_STOP;
          gate_d  = 1'b0;
          tick_d  = '0;
        end else if (at_last) begin
          state_d = ST_GATE;
          tick_d  = '0;
          step_d  = step_nxt;
          note_d  = nxt_note;
          gate_d  = |nxt_note;
          pulse_d = 1'b1;
        end else begin
          tick_d = tick_q + TICK_ONE;
          if (state_q == ST_GATE && at_gate_end) begin
            state_d = ST_REST;
            gate_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_STOP;
        gate_d  = 1'b0;
        tick_d  = '0;
      end
    endcase
  end

  always_comb begin
    ev_d   = ev_q;
    ed_d   = ed_q;
    drop_d = 1'b0;
    if (ev_q && edit_ready) begin
      ev_d = 1'b0;
    end
    // a press seen while a write is pending,
    // even on its accept cycle, is dropped
    unique case (1'b1)
      (button_valid && ev_q): begin
        drop_d = 1'b1;
      end
      (button_valid && !ev_q): begin
        ev_d = 1'b1;
        ed_d = {button_index, btn_pitch};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
      tick_q  <= '0;
      step_q  <= 4'd0;
      note_q  <= 3'd0;
      gate_q  <= 1'b0;
      pulse_q <= 1'b0;
      ev_q    <= 1'b0;
      ed_q    <= 7'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      note_q  <= note_d;
      gate_q  <= gate_d;
      pulse_q <= pulse_d;
      ev_q    <= ev_d;
      ed_q    <= ed_d;
      drop_q  <= drop_d;
    end
  end

  assign step_index = step_q;
  assign note       = note_q;
  assign gate       = gate_q;
  assign step_pulse = pulse_q;
  assign edit_valid = ev_q;
  assign edit_data  = ed_q;
  assign edit_drop  = drop_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: directed scenarios with literal
// expectations plus randomized traffic against a cycle model.
module tb_step_scheduler;

  localparam int TPS = 8;
  localparam int GT  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [47:0] beats_flat;
  logic        button_valid = 1'b0;
  logic [3:0]  button_index = 4'd0;
  logic        edit_ready = 1'b0;
  logic [3:0]  step_index;
  logic [2:0]  note;
  logic        gate;
  logic        step_pulse;
  logic        edit_valid;
  logic [6:0]  edit_data;
  logic        edit_drop;

  logic [2:0]  beats [16];

  int errors = 0;
  int checks = 0;

  // model state
  bit m_play = 0;
  int m_el = 0;
  int m_step = 0;
  int m_note = 0;
  bit m_pend = 0;
  int m_data = 0;
  bit m_drop = 0;

  step_scheduler #(
    .TICKS_PER_STEP(TPS),
    .GATE_TICKS(GT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .beats_flat(beats_flat),
    .button_valid(button_valid),
    .button_index(button_index),
    .edit_ready(edit_ready),
    .step_index(step_index),
    .note(note),
    .gate(gate),
    .step_pulse(step_pulse),
    .edit_valid(edit_valid),
    .edit_data(edit_data),
    .edit_drop(edit_drop)
  );

  always #5 clk = ~clk;

  always_comb begin
    beats_flat = '0;
    for (int i = 0; i < 16; i++)
      beats_flat[3*i +: 3] = beats[i];
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // reference: playback as elapsed cycles since start,
  // edits as a single pending slot
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_play = 0;
      m_el   = 0;
      m_step = 0;
      m_note = 0;
      m_pend = 0;
      m_data = 0;
      m_drop = 0;
    end else begin
      if (!m_play) begin
        if (run) begin
          m_play = 1;
          m_el   = 0;
          m_step = 0;
          m_note = int'(beats[0]);
        end
      end else if (!run) begin
        m_play = 0;
      end else begin
        m_el++;
        if (m_el % TPS == 0) begin
          m_step = (m_step + 1) % 16;
          m_note = int'(beats[m_step]);
        end
      end
      begin
        bit was;
        was = m_pend;
        m_drop = button_valid && was;
        if (was && edit_ready) m_pend = 0;
        if (button_valid && !was) begin
          m_pend = 1;
          m_data = int'(button_index) * 8
                 + (int'(beats[button_index]) + 1) % 8;
        end
      end
    end
  end

  always @(negedge clk) begin
    int tk;
    tk = m_el % TPS;
    chk("step_index", int'(step_index), m_step);
    chk("note", int'(note), m_note);
    chk("step_pulse", int'(step_pulse),
        int'(m_play && tk == 0));
    chk("gate", int'(gate),
        int'(m_play && tk < GT && m_note != 0));
    chk("edit_valid", int'(edit_valid), int'(m_pend));
    chk("edit_data", int'(edit_data), m_data);
    chk("edit_drop", int'(edit_drop), int'(m_drop));
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".step"}, int'(step_index), 0);
    chk({nm, ".note"}, int'(note), 0);
    chk({nm, ".gate"}, int'(gate), 0);
    chk({nm, ".pulse"}, int'(step_pulse), 0);
    chk({nm, ".ev"}, int'(edit_valid), 0);
    chk({nm, ".ed"}, int'(edit_data), 0);
    chk({nm, ".drop"}, int'(edit_drop), 0);
  endtask

  initial begin
    int gcnt;
    int pcnt;
    for (int i = 0; i < 16; i++) beats[i] = 3'd5;

    repeat (3) cyc();
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc();
    run = 1'b1;
    cyc();
    chk("start.pulse", int'(step_pulse), 1);
    chk("start.gate", int'(gate), 1);
    chk("start.note", int'(note), 5);
    chk("start.step", int'(step_index), 0);

    gcnt = 0;
    pcnt = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      gcnt += int'(gate);
      pcnt += int'(step_pulse);
    end
    chk("play.gate_cycles", gcnt, 12);
    chk("play.pulses", pcnt, 4);
    chk("play.step4", int'(step_index), 4);
    chk("play.pulse4", int'(step_pulse), 1);

    // stop on the last tick of step 4
    repeat (7) cyc();
    run = 1'b0;
    cyc();
    chk("stop.step", int'(step_index), 4);
    chk("stop.gate", int'(gate), 0);
    chk("stop.pulse", int'(step_pulse), 0);
    cyc();
    chk("stop.hold", int'(step_index), 4);
    run = 1'b1;
    cyc();
    chk("restart.step", int'(step_index), 0);
    chk("restart.pulse", int'(step_pulse), 1);
    run = 1'b0;
    cyc();

    // edit of a pitch-7 beat wraps to 0
    beats[9] = 3'd7;
    button_valid = 1'b1;
    button_index = 4'd9;
    edit_ready = 1'b0;
    cyc();
    button_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("edit9.valid", int'(edit_valid), 1);
      chk("edit9.data", int'(edit_data), 72);
      if (i < 4) cyc();
    end
    edit_ready = 1'b1;
    button_valid = 1'b1;
    button_index = 4'd3;
    cyc();
    edit_ready = 1'b0;
    button_valid = 1'b0;
    chk("accept.valid", int'(edit_valid), 0);
    chk("accept.drop", int'(edit_drop), 1);
    chk("accept.data", int'(edit_data), 72);
    cyc();
    chk("drop.once", int'(edit_drop), 0);
    beats[3] = 3'd2;
    button_valid = 1'b1;
    button_index = 4'd3;
    cyc();
    chk("edit3.valid", int'(edit_valid), 1);
    chk("edit3.data", int'(edit_data), 27);
    cyc();
    button_valid = 1'b0;
    chk("pend.drop", int'(edit_drop), 1);
    chk("pend.data", int'(edit_data), 27);
    edit_ready = 1'b1;
    cyc();
    edit_ready = 1'b0;
    chk("edit3.clear", int'(edit_valid), 0);

    // reset mid-gate with an edit pending
    run = 1'b1;
    cyc();
    button_valid = 1'b1;
    button_index = 4'd1;
    cyc();
    button_valid = 1'b0;
    chk("pre_rst.gate", int'(gate), 1);
    cyc();
    chk("pre_rst.ev", int'(edit_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    cyc();
    run = 1'b0;
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst.step", int'(step_index), 0);
    chk("post_rst.pulse", int'(step_pulse), 0);
    chk("post_rst.gate", int'(gate), 0);
    chk("post_rst.drop", int'(edit_drop), 0);

    // randomized traffic, model-checked every cycle
    run = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) run = ~run;
      button_valid = ($urandom_range(3) == 0);
      button_index = 4'($urandom_range(15));
      edit_ready = ($urandom_range(1) == 1);
      if ($urandom_range(7) == 0)
        beats[$urandom_range(15)] = 3'($urandom_range(7));
      if ($urandom_range(999) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end
    button_valid = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
